mtl_bus_bridge: RTL and testbench

// - Parametrised 6809 bus bridge for the MTL-1 memory adapter. Generalises fixed SRAM/ROM/UART decoding to NUM_REGIONS regions.
// - Each region has its own base/mask, minimum wait states and ready handshake, and gets one-hot selects.
// - Drives o_MRDY clock stretching, o_DBEN, and the registered read-data mux.
// - Sits between the top-level pins and the SRAM, SPI-flash and UART back-ends.

---
 rtl/mtl_bus_pkg.sv | 25 ++
 rtl/mtl_bus_bridge_if.sv | 40 ++++
 rtl/mtl_sync_edge.sv | 25 ++
 rtl/mtl_bus_bridge.sv | 196 +++++++++++++++++++
 tb/tb_mtl_bus_bridge.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mtl_bus_pkg.sv
// Shared types and default region table for the MTL-1 6809 bus bridge.
package mtl_bus_pkg;

    localparam int MTL_ADDR_W      = 16;
    localparam int MTL_DATA_W      = 8;
    localparam int MTL_NUM_REGIONS = 4;

    // Region 0 sits in the LSBs: 0 = F000/F000 (flash, 2 waits, lockable),
    // 1 = A000/E000, 2 = 1000/F000, 3 = 0000/F000.
    localparam logic [MTL_NUM_REGIONS*MTL_ADDR_W-1:0] MTL_REGION_BASE =
        {16'h0000, 16'h1000, 16'hA000, 16'hF000};
    localparam logic [MTL_NUM_REGIONS*MTL_ADDR_W-1:0] MTL_REGION_MASK =
        {16'hF000, 16'hF000, 16'hE000, 16'hF000};
    localparam logic [MTL_NUM_REGIONS*4-1:0] MTL_REGION_WAIT =
        {4'd0, 4'd0, 4'd0, 4'd2};
    localparam logic [MTL_NUM_REGIONS-1:0] MTL_LOCK_MASK = 4'b0001;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        WAIT,
        HOLD
    } bus_state_e;

endpackage

// File: rtl/mtl_bus_bridge_if.sv
// 6809-side pins plus region back-end signals of the bus bridge.
interface mtl_bus_bridge_if
    import mtl_bus_pkg::*;
#(
    parameter int NUM_REGIONS = MTL_NUM_REGIONS,
    parameter int ADDR_W      = MTL_ADDR_W,
    parameter int DATA_W      = MTL_DATA_W
);
    logic [ADDR_W-1:0]             i_ADDRESS_BUS;
    logic                          i_RW;
    logic                          i_E;
    logic                          i_Q;
    logic                          i_FT_CS;
    logic [DATA_W-1:0]             i_DATA_IN;
    logic [DATA_W-1:0]             o_DATA_OUT;
    logic                          o_DATA_OE;
    logic                          o_DBEN;
    logic                          o_MRDY;
    logic [NUM_REGIONS-1:0]        o_region_ce;
    logic [ADDR_W-1:0]             o_addr;
    logic [DATA_W-1:0]             o_wdata;
    logic                          o_wstrobe;
    logic [NUM_REGIONS*DATA_W-1:0] i_region_rdata;
    logic [NUM_REGIONS-1:0]        i_region_ready;
    logic                          o_timeout;

    modport master (
        output i_ADDRESS_BUS, i_RW, i_E, i_Q, i_FT_CS, i_DATA_IN,
               i_region_rdata, i_region_ready,
        input  o_DATA_OUT, o_DATA_OE, o_DBEN, o_MRDY, o_region_ce,
               o_addr, o_wdata, o_wstrobe, o_timeout
    );

    modport slave (
        input  i_ADDRESS_BUS, i_RW, i_E, i_Q, i_FT_CS, i_DATA_IN,
               i_region_rdata, i_region_ready,
        output o_DATA_OUT, o_DATA_OE, o_DBEN, o_MRDY, o_region_ce,
               o_addr, o_wdata, o_wstrobe, o_timeout
    );
endinterface

// File: rtl/mtl_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus an edge register
// giving single-cycle rise/fall pulses.
module mtl_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [2:0] sh_q, sh_d;

    always_comb begin
        sh_d = {sh_q[1:0], i_async};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sh_q <= '0;
        else     sh_q <= sh_d;
    end

    assign o_level = sh_q[1];
    assign o_rise  = sh_q[1] & ~sh_q[2];
    assign o_fall  = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/mtl_bus_bridge.sv
// 6809 bus bridge: region decode, MRDY clock stretching, read mux, write strobe.
// Optional bounded stretch with sticky timeout flag when MTL_BUS_TIMEOUT_EN is defined.
module mtl_bus_bridge
    import mtl_bus_pkg::*;
#(
    parameter int                               NUM_REGIONS = MTL_NUM_REGIONS,
    parameter int                               ADDR_W      = MTL_ADDR_W,
    parameter int                               DATA_W      = MTL_DATA_W,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]    REGION_BASE = MTL_REGION_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]    REGION_MASK = MTL_REGION_MASK,
    parameter logic [NUM_REGIONS*4-1:0]         REGION_WAIT = MTL_REGION_WAIT,
    parameter logic [NUM_REGIONS-1:0]           LOCK_MASK   = MTL_LOCK_MASK,
    parameter int                               TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0]                FLOAT_VAL   = 8'hFF
) (
    input  logic           clk,
    input  logic           reset,
    mtl_bus_bridge_if.slave bus
);
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    bus_state_e             state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   rw_q, rw_d;
    logic [IDX_W-1:0]       sel_q, sel_d;
    logic [NUM_REGIONS-1:0] ce_q, ce_d;
    logic                   dben_q, dben_d;
    logic                   mrdy_q, mrdy_d;
    logic                   wstrobe_q, wstrobe_d;
    logic                   abort_q, abort_d;
    logic                   timeout_q, timeout_d;
    logic [DATA_W-1:0]      dout_q, dout_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [3:0]             wcnt_q, wcnt_d;

    logic e_level, e_fall, q_rise;
    logic e_rise_unused, q_level_unused, q_fall_unused;
    logic [NUM_REGIONS-1:0] hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   force_exit;
    logic [DATA_W-1:0]      rdata_arr [NUM_REGIONS];
    logic [3:0]             wait_arr  [NUM_REGIONS];

    mtl_sync_edge u_sync_e (
        .clk(clk), .rst(reset), .i_async(bus.i_E),
        .o_level(e_level), .o_rise(e_rise_unused), .o_fall(e_fall)
    );

    mtl_sync_edge u_sync_q (
        .clk(clk), .rst(reset), .i_async(bus.i_Q),
        .o_level(q_level_unused), .o_rise(q_rise), .o_fall(q_fall_unused)
    );

    // Locked regions drop out of the decode while flash programming holds FT_CS low.
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
        assign hit[gi] = ((addr_q & REGION_MASK[gi*ADDR_W +: ADDR_W]) ==
                          REGION_BASE[gi*ADDR_W +: ADDR_W]) &&
                         !(LOCK_MASK[gi] && !bus.i_FT_CS);
        assign rdata_arr[gi] = bus.i_region_rdata[gi*DATA_W +: DATA_W];
        assign wait_arr[gi]  = REGION_WAIT[gi*4 +: 4];
    end

    always_comb begin
        hit_idx = '0;
        for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
            if (hit[k]) hit_idx = IDX_W'(k);
        end
    end

`ifdef MTL_BUS_TIMEOUT_EN
    logic [8:0] tcnt_q, tcnt_d;

    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q == DECODE)                      tcnt_d = '0;
        else if (state_q == WAIT && tcnt_q != '1)   tcnt_d = tcnt_q + 9'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tcnt_q <= '0;
        else       tcnt_q <= tcnt_d;
    end

    // tcnt_q counts completed WAIT cycles, so this fires on cycle TIMEOUT_CYC+1.
    assign force_exit = (state_q == WAIT) && (tcnt_q >= 9'(TIMEOUT_CYC));
`else
    assign force_exit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        sel_d     = sel_q;
        ce_d      = ce_q;
        dben_d    = dben_q;
        mrdy_d    = mrdy_q;
        dout_d    = dout_q;
        wdata_d   = wdata_q;
        wstrobe_d = 1'b0;
        wcnt_d    = wcnt_q;
        abort_d   = abort_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (q_rise) begin
                    addr_d  = bus.i_ADDRESS_BUS;
                    rw_d    = bus.i_RW;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (|hit) begin
                    sel_d          = hit_idx;
                    wcnt_d         = wait_arr[hit_idx];
                    ce_d           = '0;
                    ce_d[hit_idx]  = 1'b1;
                    dben_d         = 1'b0;
                    mrdy_d         = 1'b0;
                    abort_d        = 1'b0;
                    state_d        = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q == 4'd0 && bus.i_region_ready[sel_q]) begin
                    if (rw_q) dout_d = rdata_arr[sel_q];
                    mrdy_d  = 1'b1;
                    state_d = HOLD;
                end else if (force_exit) begin
                    dout_d    = FLOAT_VAL;
                    timeout_d = 1'b1;
                    abort_d   = 1'b1;
                    mrdy_d    = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (e_fall) begin
                    if (!rw_q && !abort_q) begin
                        wdata_d   = bus.i_DATA_IN;
                        wstrobe_d = 1'b1;
                    end
                    ce_d    = '0;
                    dben_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            sel_q     <= '0;
            ce_q      <= '0;
            dben_q    <= 1'b1;
            mrdy_q    <= 1'b1;
            dout_q    <= '0;
            wdata_q   <= '0;
            wstrobe_q <= 1'b0;
            wcnt_q    <= '0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            sel_q     <= sel_d;
            ce_q      <= ce_d;
            dben_q    <= dben_d;
            mrdy_q    <= mrdy_d;
            dout_q    <= dout_d;
            wdata_q   <= wdata_d;
            wstrobe_q <= wstrobe_d;
            wcnt_q    <= wcnt_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_DATA_OUT  = dout_q;
    assign bus.o_DATA_OE   = (state_q == HOLD) && rw_q && e_level;
    assign bus.o_DBEN      = dben_q;
    assign bus.o_MRDY      = mrdy_q;
    assign bus.o_region_ce = ce_q;
    assign bus.o_addr      = addr_q;
    assign bus.o_wdata     = wdata_q;
    assign bus.o_wstrobe   = wstrobe_q;
    assign bus.o_timeout   = timeout_q;
endmodule

// File: tb/tb_mtl_bus_bridge.sv
// Randomised bench for mtl_bus_bridge against a region-table reference model.
// Build with MTL_BUS_TIMEOUT_EN defined to expect the bounded-stretch behaviour.
module tb_mtl_bus_bridge;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] bases [4] = '{16'hF000, 16'hA000, 16'h1000, 16'h0000};
    logic [15:0] masks [4] = '{16'hF000, 16'hE000, 16'hF000, 16'hF000};
    int          waits [4] = '{2, 0, 0, 0};
    logic        locks [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    logic [7:0] exp_wdata   = 8'h00;
    logic       exp_timeout = 1'b0;
    int         txn_no      = 0;

    always #5 clk = ~clk;

    mtl_bus_bridge_if #(.NUM_REGIONS(4), .ADDR_W(16), .DATA_W(8)) bus ();

    mtl_bus_bridge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_region(input logic [15:0] a, input logic ftcs);
        for (int i = 0; i < 4; i++) begin
            if (((a & masks[i]) == bases[i]) && !(locks[i] && !ftcs)) return i;
        end
        return -1;
    endfunction

    // One 6809 cycle: Q rises, E rises, hold both until MRDY is released, then Q falls, E falls.
    task automatic run_txn(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                           input logic ftcs, input int delay);
        int k, exp_lo, lo, strobes, rel_c;
        logic [3:0] ce_or;
        logic dben_lo, released, done, timed, oe_at;
        logic [7:0] dout_at, wd_at;
        logic [7:0] rd [4];

        k = ref_region(a, ftcs);
        for (int i = 0; i < 4; i++) rd[i] = 8'($urandom);
        bus.i_region_rdata = {rd[3], rd[2], rd[1], rd[0]};
        bus.i_region_ready = 4'hF;
        if (delay > 0 && k >= 0) bus.i_region_ready[k] = 1'b0;
        bus.i_ADDRESS_BUS = a;
        bus.i_RW          = rw;
        bus.i_DATA_IN     = wd;
        bus.i_FT_CS       = ftcs;

        exp_lo = 0;
        timed  = 1'b0;
        if (k >= 0) begin
            exp_lo = waits[k] + 1;
            if (delay > exp_lo) exp_lo = delay;
`ifdef MTL_BUS_TIMEOUT_EN
            if (exp_lo > 256) begin
                exp_lo = 256;
                timed  = 1'b1;
            end
`endif
        end

        lo = 0; strobes = 0; rel_c = 0; ce_or = '0;
        dben_lo = 1'b0; released = 1'b0; done = 1'b0;
        oe_at = 1'b0; dout_at = '0; wd_at = '0;

        @(negedge clk);
        bus.i_Q = 1'b1;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (!bus.o_MRDY) lo++;
            ce_or = ce_or | bus.o_region_ce;
            if (!bus.o_DBEN) dben_lo = 1'b1;
            if (bus.o_wstrobe) begin
                strobes++;
                wd_at = bus.o_wdata;
            end
            if (c == 1) bus.i_E = 1'b1;
            if (delay > 0 && k >= 0 && lo == delay) bus.i_region_ready[k] = 1'b1;
            if (!released && ((k >= 0 && lo > 0 && bus.o_MRDY) || (k < 0 && c == 12))) begin
                released = 1'b1;
                rel_c    = c;
                oe_at    = bus.o_DATA_OE;
                dout_at  = bus.o_DATA_OUT;
                bus.i_Q  = 1'b0;
            end else if (released && c == rel_c + 1) begin
                bus.i_E = 1'b0;
            end else if (released && c == rel_c + 8) begin
                done = 1'b1;
            end
        end
        bus.i_Q = 1'b0;
        bus.i_E = 1'b0;
        if (!done) repeat (8) @(negedge clk);

        check_eq("completed", 32'(done), 32'd1);
        check_eq("region_ce", 32'(ce_or), (k < 0) ? 32'd0 : (32'd1 << k));
        check_eq("dben_low", 32'(dben_lo), 32'(k >= 0));
        check_eq("mrdy_low_clk", 32'(lo), 32'(exp_lo));
        check_eq("wstrobe_cnt", 32'(strobes), 32'(k >= 0 && !rw && !timed));
        if (strobes == 1) check_eq("wdata_at_strobe", 32'(wd_at), 32'(wd));
        if (k >= 0) check_eq("o_addr", 32'(bus.o_addr), 32'(a));
        if (k >= 0 && rw) begin
            check_eq("data_oe", 32'(oe_at), 32'd1);
            check_eq("data_out", 32'(dout_at), timed ? 32'hFF : 32'(rd[k]));
        end
        if (k >= 0 && !rw && !timed) exp_wdata = wd;
        if (timed) exp_timeout = 1'b1;
        check_eq("o_wdata", 32'(bus.o_wdata), 32'(exp_wdata));
        check_eq("o_timeout", 32'(bus.o_timeout), 32'(exp_timeout));
        check_eq("idle_ce", 32'(bus.o_region_ce), 32'd0);
        check_eq("idle_dben", 32'(bus.o_DBEN), 32'd1);
        check_eq("idle_oe", 32'(bus.o_DATA_OE), 32'd0);

        txn_no++;
        $display("txn %0d addr=%h rw=%0d ftcs=%0d delay=%0d region=%0d mrdy_low=%0d strobes=%0d",
                 txn_no, a, rw, ftcs, delay, k, lo, strobes);
    endtask

    initial begin
        bus.i_ADDRESS_BUS  = '0;
        bus.i_RW           = 1'b1;
        bus.i_E            = 1'b0;
        bus.i_Q            = 1'b0;
        bus.i_FT_CS        = 1'b1;
        bus.i_DATA_IN      = '0;
        bus.i_region_rdata = '0;
        bus.i_region_ready = '1;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        check_eq("rst_mrdy", 32'(bus.o_MRDY), 32'd1);
        check_eq("rst_dben", 32'(bus.o_DBEN), 32'd1);
        check_eq("rst_oe", 32'(bus.o_DATA_OE), 32'd0);
        check_eq("rst_ce", 32'(bus.o_region_ce), 32'd0);
        check_eq("rst_wstrobe", 32'(bus.o_wstrobe), 32'd0);
        check_eq("rst_timeout", 32'(bus.o_timeout), 32'd0);
        check_eq("rst_dout", 32'(bus.o_DATA_OUT), 32'd0);
        check_eq("rst_addr", 32'(bus.o_addr), 32'd0);
        check_eq("rst_wdata", 32'(bus.o_wdata), 32'd0);
        $display("txn 0 reset state sampled");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_txn(16'hF010, 1'b1, 8'h00, 1'b1, 0);     // region 0 read, 2 waits
        run_txn(16'h0123, 1'b0, 8'hC3, 1'b1, 0);     // region 3 write
        run_txn(16'h9000, 1'b1, 8'h00, 1'b1, 0);     // unmapped
        run_txn(16'hF000, 1'b1, 8'h00, 1'b0, 0);     // region 0 locked
        run_txn(16'hA5A5, 1'b0, 8'h5A, 1'b1, 3);     // late ready dominates 0 waits
        run_txn(16'h1FFF, 1'b1, 8'h00, 1'b1, 1);     // ready after first WAIT clk
        run_txn(16'hF200, 1'b1, 8'h00, 1'b1, 300);   // long stall on region 0

        // Reset while stretched in WAIT must release the bus immediately.
        bus.i_region_ready = 4'h0;
        bus.i_ADDRESS_BUS  = 16'hF010;
        bus.i_RW           = 1'b1;
        bus.i_FT_CS        = 1'b1;
        @(negedge clk);
        bus.i_Q = 1'b1;
        for (int c = 0; c < 20 && bus.o_MRDY; c++) @(negedge clk);
        check_eq("pre_rst_mrdy", 32'(bus.o_MRDY), 32'd0);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_mrdy", 32'(bus.o_MRDY), 32'd1);
        check_eq("async_rst_dben", 32'(bus.o_DBEN), 32'd1);
        check_eq("async_rst_ce", 32'(bus.o_region_ce), 32'd0);
        check_eq("async_rst_wstrobe", 32'(bus.o_wstrobe), 32'd0);
        bus.i_Q = 1'b0;
        bus.i_E = 1'b0;
        exp_wdata   = 8'h00;
        exp_timeout = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        $display("txn r reset applied during WAIT");
        run_txn(16'hF010, 1'b1, 8'h00, 1'b1, 0);

        for (int n = 0; n < 24; n++) begin
            logic [15:0] a;
            logic rw, ftcs;
            int d;
            a    = 16'($urandom);
            rw   = 1'($urandom);
            ftcs = ($urandom_range(0, 3) != 0);
            d    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            run_txn(a, rw, 8'($urandom), ftcs, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
